barrel_seq_shifter: RTL and testbench

- Multi-cycle shift sequencer that sits directly upstream of the 8-bit combinational barrel shifter stage.
- Extends the reach of that stage: accepts one data byte plus a wide shift amount (0..2^SW-1) over a valid/ready handshake.
- Applies the shift as successive passes of at most 7 positions, one pass per clock.
- Returns the result over a second valid/ready handshake, together with the number of passes used.

---
 rtl/barrel_seq_shifter.sv | 117 +++++++++++
 tb/tb_barrel_seq_shifter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/barrel_seq_shifter.sv
// rtl/barrel_seq_shifter.sv - multi-pass shift sequencer, at most MAXSTEP positions per clock
// Optional BSEQ_ROTATE_EN: passes rotate left instead of shifting left with zero fill.
module barrel_seq_shifter #(
  parameter int DW      = 8,
  parameter int SW      = 5,
  parameter int MAXSTEP = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [SW-1:0] in_amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [SW-1:0] out_passes,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [SW-1:0] STEP_MAX = SW'(MAXSTEP);
  localparam logic [SW-1:0] ONE      = SW'(1);

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [SW-1:0] rem_q, rem_d;
  logic [SW-1:0] passes_q, passes_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [SW-1:0] out_passes_q, out_passes_d;

  logic [SW-1:0] step;
  logic [DW-1:0] shifted;

  assign step = (rem_q > STEP_MAX) ? STEP_MAX : rem_q;

`ifdef BSEQ_ROTATE_EN
  logic [2*DW-1:0] rot_wide;
  // Upper half of the doubled word shifted left is the rotate-left result.
  assign rot_wide = {data_q, data_q} << step;
  assign shifted  = rot_wide[2*DW-1:DW];
`else
  assign shifted = data_q << step;
`endif

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    rem_d        = rem_q;
    passes_d     = passes_q;
    out_data_d   = out_data_q;
    out_passes_d = out_passes_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
          rem_d    = in_amt;
          passes_d = '0;
          if (in_amt != '0) begin
            state_d = SHIFT;
          end else begin
            state_d      = DONE;
            out_data_d   = in_data;
            out_passes_d = '0;
          end
        end
      end
      SHIFT: begin
        data_d   = shifted;
        rem_d    = rem_q - step;
        passes_d = passes_q + ONE;
        if (rem_q <= STEP_MAX) begin
          state_d      = DONE;
          out_data_d   = shifted;
          out_passes_d = passes_q + ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      rem_q        <= '0;
      passes_q     <= '0;
      out_data_q   <= '0;
      out_passes_q <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      rem_q        <= rem_d;
      passes_q     <= passes_d;
      out_data_q   <= out_data_d;
      out_passes_q <= out_passes_d;
    end
  end

  // Result registers are loaded only on entry to DONE so they hold through IDLE.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == SHIFT) || (state_q == DONE);
  assign out_data   = out_data_q;
  assign out_passes = out_passes_q;

endmodule

// File: tb/tb_barrel_seq_shifter.sv
// tb/tb_barrel_seq_shifter.sv - directed self-checking bench for barrel_seq_shifter
module tb_barrel_seq_shifter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] out_passes;
  logic       busy;

  int errors = 0;
  int checks = 0;

  barrel_seq_shifter #(.DW(8), .SW(5), .MAXSTEP(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_passes (out_passes),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a request, waits (bounded) for acceptance, returns just after the accept edge.
  task automatic issue(input logic [7:0] d, input logic [4:0] a, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    in_amt   = '0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (out_passes !== 5'd0) begin errors++; $display("FAIL reset_out_passes: got %0d expected 0", out_passes); end
    rst_n = 1'b1;
  endtask

  task automatic test_shift();
    logic [7:0] d_t[3] = '{8'hB5, 8'h81, 8'hFF};
    logic [4:0] a_t[3] = '{5'd3, 5'd20, 5'd31};
`ifdef BSEQ_ROTATE_EN
    logic [7:0] e_t[3] = '{8'hAD, 8'h18, 8'hFF};
`else
    logic [7:0] e_t[3] = '{8'hA8, 8'h00, 8'h00};
`endif
    int p_t[3] = '{1, 3, 5};
    bit ok;
    int lat;
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b1;
      issue(d_t[i], a_t[i], ok);
      checks++; if (!ok) begin errors++; $display("FAIL shift_accept[%0d]: got in_ready=0 expected 1", i); end
      lat = 0;
      while (!out_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      checks++; if (lat != p_t[i]) begin errors++; $display("FAIL shift_latency[%0d]: got %0d expected %0d", i, lat, p_t[i]); end
      checks++; if (out_data !== e_t[i]) begin errors++; $display("FAIL shift_data[%0d]: got %h expected %h", i, out_data, e_t[i]); end
      checks++; if (out_passes !== 5'(p_t[i])) begin errors++; $display("FAIL shift_passes[%0d]: got %0d expected %0d", i, out_passes, p_t[i]); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL shift_return_idle[%0d]: got rdy=%b vld=%b busy=%b expected 1 0 0", i, in_ready, out_valid, busy); end
      checks++; if (out_data !== e_t[i]) begin errors++; $display("FAIL shift_hold_idle[%0d]: got %h expected %h", i, out_data, e_t[i]); end
    end
  endtask

  task automatic test_zero_amt();
    bit ok;
    out_ready = 1'b1;
    issue(8'h5A, 5'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_accept: got in_ready=0 expected 1"); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_done_after_accept: got out_valid=%b expected 1", out_valid); end
    checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL zero_data: got %h expected 5a", out_data); end
    checks++; if (out_passes !== 5'd0) begin errors++; $display("FAIL zero_passes: got %0d expected 0", out_passes); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
`ifdef BSEQ_ROTATE_EN
    logic [7:0] exp_bp = 8'h01;
`else
    logic [7:0] exp_bp = 8'h00;
`endif
    out_ready = 1'b0;
    issue(8'h01, 5'd8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got in_ready=0 expected 1"); end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL bp_latency: got %0d expected 2", lat); end
    in_valid = 1'b1;
    in_data  = 8'h03;
    in_amt   = 5'd1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_handshake[%0d]: got vld=%b rdy=%b expected 1 0", c, out_valid, in_ready); end
      checks++; if (out_data !== exp_bp || out_passes !== 5'd2) begin errors++; $display("FAIL bp_hold_result[%0d]: got %h/%0d expected %h/2", c, out_data, out_passes, exp_bp); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accepted: got rdy=%b busy=%b expected 0 1", in_ready, busy); end
    in_valid = 1'b0;
    in_data  = 8'hFF;
    in_amt   = 5'd31;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h06 || out_passes !== 5'd1) begin errors++; $display("FAIL b2b_result: got vld=%b %h/%0d expected 1 06/1", out_valid, out_data, out_passes); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bit ok;
    int seen;
    out_ready = 1'b1;
    issue(8'hFF, 5'd31, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_accept: got in_ready=0 expected 1"); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_mid_shift: got busy=%b vld=%b expected 1 0", busy, out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_async: got rdy=%b vld=%b busy=%b expected 1 0 0", in_ready, out_valid, busy); end
    checks++; if (out_data !== 8'h00 || out_passes !== 5'd0) begin errors++; $display("FAIL abort_outputs_cleared: got %h/%0d expected 00/0", out_data, out_passes); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_result: got %0d out_valid cycles expected 0", seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: got in_ready=%b expected 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_zero_amt();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
